tilemap_render: RTL
===================

TILEMAP_RENDER -- requirements
Module: tilemap_render

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning map width in characters (power of 2).
REQ-002 SHALL have parameter ROWS, default 32, meaning map height in characters (power of 2).
REQ-003 SHALL have parameter CHAR_H, default 8, meaning glyph height in lines (8 or 16); glyph width fixed 8 px.
REQ-004 SHALL have parameter ACT_W, default 512, meaning active pixels per line; ACT_H, default 256, meaning active lines.
REQ-005 SHALL have ports: clk  in  1  pixel clock; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: hcnt  in  10  pixel counter; vcnt  in  10  line counter.
REQ-007 SHALL have ports: scroll_x  in  log2(COLS*8)  pixel scroll; scroll_y  in  log2(ROWS*CHAR_H)  line scroll; scroll_wr  in  1  shadow-load strobe.
REQ-008 SHALL have ports: chram_addr  out  log2(COLS*ROWS)  map RAM address; chram_data  in  8  char code; attr_data  in  8  {fg[7:4],bg[3:0]}.
REQ-009 SHALL have ports: chrom_addr  out  8+log2(CHAR_H)  glyph ROM address; chrom_data  in  8  glyph row, bit 7 leftmost.
REQ-010 SHALL have ports: pix_on  out  1  glyph bit; pix_fg  out  4; pix_bg  out  4; pix_valid  out  1  active-region pixel; frame_start  out  1  pulse.

Function
REQ-011 Effective coords: ex = (hcnt + scroll_x) mod COLS*8, ey = (vcnt + scroll_y) mod ROWS*CHAR_H; truncation gives wrap, no saturation.
REQ-012 Stage 0 (registered): chram_addr = {ey / CHAR_H, ex / 8}; stage carries ex[2:0], ey mod CHAR_H, active flag.
REQ-013 Map/attr RAM: 1-cycle synchronous read; stage 1 registers chrom_addr = {chram_data, ey mod CHAR_H}, attr_data.
REQ-014 Glyph ROM: 1-cycle synchronous read; stage 2 selects chrom_data[7 - ex[2:0]].
REQ-015 Stage 3 registers pix_on, pix_fg, pix_bg, pix_valid; total latency hcnt/vcnt -> pixel outputs = 4 cycles, fixed, no stalls.
REQ-016 active = (hcnt < ACT_W) && (vcnt < ACT_H); when inactive pix_on=0, pix_fg=0, pix_bg=0, pix_valid=0 at output; addresses still driven.
REQ-017 scroll_wr=1 latches scroll_x/scroll_y into shadow registers; active scroll registers load from shadow on hcnt==0 && vcnt==0 only (no mid-frame tearing).
REQ-018 scroll_wr coincident with frame start: active takes previous shadow, new value applies next frame.
REQ-019 frame_start = 1 for one cycle, aligned with the output pixel of hcnt=0, vcnt=0 (4-cycle delayed).
REQ-020 Non-contiguous hcnt/vcnt (jumps) SHALL be handled without internal state beyond the pipeline; output follows inputs at 4-cycle delay.

Reset
REQ-021 reset_n low SHALL asynchronously clear all pipeline, shadow and active scroll registers; chram_addr=0, chrom_addr=0, pix_*=0, frame_start=0.
REQ-022 Reset release mid-frame: outputs valid 4 cycles after first clock edge; scroll = 0 until next shadow load and frame start.

Structure
REQ-023 Shared package SHALL hold glyph width constant (8), latency constant (4) and the $clog2-derived width helpers.
REQ-024 One sub-module natural: tilemap_scroll (shadow/active scroll registers and frame-start load); pipeline stays in top.

Verification
REQ-025 Scroll 0, map(0,0)=0x41, ROM[0x41 row 0]=0x80, hcnt=0,vcnt=0 -> chram_addr=0 at cycle 1, pix_on=1 at cycle 4, pix_on=0 for hcnt=1.
REQ-026 scroll_x=8, hcnt=504, COLS=64 -> ex=0, chram_addr column 0 (wrap); scroll_y=255, vcnt=1, ROWS*CHAR_H=256 -> ey=0.
REQ-027 scroll_wr with scroll_x=3 at vcnt=100 -> no change until next hcnt=0,vcnt=0; following frame pixel at hcnt=0 uses ex=3.
REQ-028 attr_data=0xA5 -> pix_fg=0xA, pix_bg=0x5 on matching 8 pixels; hcnt=512 -> pix_valid=0, colours 0.
REQ-029 CHAR_H=16 build: vcnt=15 -> chrom_addr low 4 bits=0xF, chram_addr row 0; vcnt=16 -> row 1.
REQ-030 reset_n asserted mid-line -> all outputs 0 immediately (no clock); after release, frame_start 1 pulse 4 cycles after hcnt=0,vcnt=0.

Source files
------------

// File: rtl/tilemap_render_pkg.sv
// Shared constants, width helpers and pipeline flag type for the tile-map renderer.
package tilemap_render_pkg;
  localparam int GLYPH_W  = 8;
  localparam int GLYPH_SH = $clog2(GLYPH_W);
  localparam int LATENCY  = 4;
  localparam int CNT_W    = 10;

  typedef struct packed {
    logic act;
    logic fs;
  } pipe_flags_t;

  function automatic int log2w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/tilemap_scroll.sv
// Shadow/active scroll registers; active copy reloads only at the frame origin.
module tilemap_scroll
  import tilemap_render_pkg::*;
#(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [XW-1:0] scroll_x,
  input  logic [YW-1:0] scroll_y,
  input  logic          scroll_wr,
  input  logic          frame0,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y
);
  logic [XW-1:0] sh_x, ac_x;
  logic [YW-1:0] sh_y, ac_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x <= '0;
      sh_y <= '0;
      ac_x <= '0;
      ac_y <= '0;
    end else begin
      if (scroll_wr) begin
        sh_x <= scroll_x;
        sh_y <= scroll_y;
      end
      if (frame0) begin
        ac_x <= sh_x;
        ac_y <= sh_y;
      end
    end
  end

  // Bypass so the origin pixel already sees the value being loaded; a write in
  // that same cycle only lands in the shadow and waits for the next frame.
  assign cur_x = frame0 ? sh_x : ac_x;
  assign cur_y = frame0 ? sh_y : ac_y;
endmodule

// File: rtl/tilemap_render.sv
// Character tile-map renderer: fixed 4-cycle pipeline from raster counters to pixel.
module tilemap_render
  import tilemap_render_pkg::*;
#(
  parameter int COLS   = 64,
  parameter int ROWS   = 32,
  parameter int CHAR_H = 8,
  parameter int ACT_W  = 512,
  parameter int ACT_H  = 256
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [CNT_W-1:0]                    hcnt,
  input  logic [CNT_W-1:0]                    vcnt,
  input  logic [log2w(COLS*GLYPH_W)-1:0]      scroll_x,
  input  logic [log2w(ROWS*CHAR_H)-1:0]       scroll_y,
  input  logic                                scroll_wr,
  output logic [log2w(COLS*ROWS)-1:0]         chram_addr,
  input  logic [7:0]                          chram_data,
  input  logic [7:0]                          attr_data,
  output logic [8+log2w(CHAR_H)-1:0]          chrom_addr,
  input  logic [7:0]                          chrom_data,
  output logic                                pix_on,
  output logic [3:0]                          pix_fg,
  output logic [3:0]                          pix_bg,
  output logic                                pix_valid,
  output logic                                frame_start
);
  localparam int XW = log2w(COLS*GLYPH_W);
  localparam int YW = log2w(ROWS*CHAR_H);
  localparam int LW = log2w(CHAR_H);
  localparam int ST = LATENCY-1;

  logic          frame0, act;
  logic [XW-1:0] sx, ex;
  logic [YW-1:0] sy, ey;
  pipe_flags_t   s0;

  assign frame0 = (hcnt == '0) && (vcnt == '0);
  assign act    = ({1'b0, hcnt} < 11'(ACT_W)) && ({1'b0, vcnt} < 11'(ACT_H));
  // Map dimensions are powers of two, so truncating the sum is the wrap.
  assign ex     = hcnt[XW-1:0] + sx;
  assign ey     = vcnt[YW-1:0] + sy;
  assign s0     = '{act: act, fs: frame0};

  tilemap_scroll #(.XW(XW), .YW(YW)) u_scroll (
    .clk      (clk),
    .reset_n  (reset_n),
    .scroll_x (scroll_x),
    .scroll_y (scroll_y),
    .scroll_wr(scroll_wr),
    .frame0   (frame0),
    .cur_x    (sx),
    .cur_y    (sy)
  );

  pipe_flags_t [ST-1:0]               flg_pipe;
  logic        [ST-1:0][GLYPH_SH-1:0] xo_pipe;
  logic        [1:0][LW-1:0]          yo_pipe;
  logic        [7:0]                  attr_q;
  logic                               run_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chram_addr  <= '0;
      flg_pipe    <= '0;
      xo_pipe     <= '0;
      yo_pipe     <= '0;
      attr_q      <= '0;
      run_q       <= 1'b0;
      pix_on      <= 1'b0;
      pix_fg      <= '0;
      pix_bg      <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      chram_addr  <= {ey[YW-1:LW], ex[XW-1:GLYPH_SH]};
      flg_pipe    <= {flg_pipe[ST-2:0], s0};
      xo_pipe     <= {xo_pipe[ST-2:0], ex[GLYPH_SH-1:0]};
      yo_pipe     <= {yo_pipe[0], ey[LW-1:0]};
      attr_q      <= attr_data;
      // Bit 7 is the leftmost pixel, so the column index is inverted.
      pix_on      <= flg_pipe[ST-1].act & chrom_data[~xo_pipe[ST-1]];
      pix_fg      <= flg_pipe[ST-1].act ? attr_q[7:4] : 4'h0;
      pix_bg      <= flg_pipe[ST-1].act ? attr_q[3:0] : 4'h0;
      pix_valid   <= flg_pipe[ST-1].act;
      frame_start <= flg_pipe[ST-1].fs;
    end
  end

  // The glyph address is formed straight from the map RAM's registered output
  // to hold the 4-cycle budget; held at zero until the first clock after reset.
  assign chrom_addr = run_q ? {chram_data, yo_pipe[1]} : '0;
endmodule
